// File: rtl/booth_shift_reg.sv
// Booth multiplier shift register: {A, Q, Q[-1]} with arithmetic right shift.
// Optional sync clear port clr when BOOTH_SHIFT_REG_SYNC_CLR_EN is defined.
module booth_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef BOOTH_SHIFT_REG_SYNC_CLR_EN
    input  logic             clr,
`endif
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d_q,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d_a,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q_m1,
    output logic [1:0]       pair,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] src_a;
    logic             sync_clr;

`ifdef BOOTH_SHIFT_REG_SYNC_CLR_EN
    assign sync_clr = clr;
`else
    assign sync_clr = 1'b0;
`endif

    assign done = (cnt_q == CNT_W'(WIDTH));

    // d_a only reaches the shifter for op=10, keeping stray X out of state.
    always_comb begin
        src_a = a_q;
        if (op == 2'b10) begin
            src_a = d_a;
        end
    end

    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        qm1_d = qm1_q;
        cnt_d = cnt_q;
        if (sync_clr) begin
            a_d   = '0;
            q_d   = '0;
            qm1_d = 1'b0;
            cnt_d = '0;
        end else if (en) begin
            if (load) begin
                a_d   = '0;
                q_d   = d_q;
                qm1_d = 1'b0;
                cnt_d = '0;
            end else begin
                unique case (op)
                    2'b01, 2'b10: begin
                        if (!done) begin
                            a_d   = {src_a[WIDTH-1], src_a[WIDTH-1:1]};
                            q_d   = {src_a[0], q_q[WIDTH-1:1]};
                            qm1_d = q_q[0];
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    2'b11: begin
                        a_d = '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
            cnt_q <= cnt_d;
        end
    end

    assign a_out = a_q;
    assign q_out = q_q;
    assign q_m1  = qm1_q;
    assign pair  = {q_q[0], qm1_q};
    assign count = cnt_q;

endmodule

// File: tb/tb_booth_shift_reg.sv
// Directed bench for booth_shift_reg (WIDTH=8) with a concatenation-level model.
// Define BOOTH_SHIFT_REG_SYNC_CLR_EN to also exercise the clr port.
module tb_booth_shift_reg;

    localparam int W = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clr;
    logic          en;
    logic          load;
    logic [W-1:0]  d_q;
    logic [1:0]    op;
    logic [W-1:0]  d_a;
    logic [W-1:0]  a_out;
    logic [W-1:0]  q_out;
    logic          q_m1;
    logic [1:0]    pair;
    logic [CW-1:0] count;
    logic          done;

    int checks = 0;
    int errors = 0;

    booth_shift_reg #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef BOOTH_SHIFT_REG_SYNC_CLR_EN
        .clr     (clr),
`endif
        .en      (en),
        .load    (load),
        .d_q     (d_q),
        .op      (op),
        .d_a     (d_a),
        .a_out   (a_out),
        .q_out   (q_out),
        .q_m1    (q_m1),
        .pair    (pair),
        .count   (count),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Model: treat {A,Q,q_m1} as one signed 17-bit number.
    logic [W-1:0] m_a, m_q;
    logic         m_m1;
    int           m_cnt;

    function automatic logic [2*W:0] sra(input logic [W-1:0] a,
                                         input logic [W-1:0] q,
                                         input logic m);
        logic signed [2*W:0] v;
        v = {a, q, m};
        return v >>> 1;
    endfunction

    logic model_clr;
`ifdef BOOTH_SHIFT_REG_SYNC_CLR_EN
    assign model_clr = clr;
`else
    assign model_clr = 1'b0;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || model_clr) begin
            m_a <= '0; m_q <= '0; m_m1 <= 1'b0; m_cnt <= 0;
        end else if (en) begin
            if (load) begin
                m_a <= '0; m_q <= d_q; m_m1 <= 1'b0; m_cnt <= 0;
            end else if ((op == 2'b01 || op == 2'b10) && m_cnt < W) begin
                {m_a, m_q, m_m1} <= sra(op == 2'b10 ? d_a : m_a, m_q, m_m1);
                m_cnt <= m_cnt + 1;
            end else if (op == 2'b11) begin
                m_a <= '0;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.a", 16'(a_out), 16'(m_a));
        chk("m.q", 16'(q_out), 16'(m_q));
        chk("m.m1", 16'(q_m1), 16'(m_m1));
        chk("m.pair", 16'(pair), 16'({m_q[0], m_m1}));
        chk("m.cnt", 16'(count), 16'(m_cnt));
        chk("m.done", 16'(done), 16'(m_cnt == W));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic [1:0] o,
                         input logic [W-1:0] dq, input logic [W-1:0] da);
        load = l; op = o; d_q = dq; d_a = da;
    endtask

    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 2'b01, 'x, 'x);
            step();
        end
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0; en = 1'b0;
        drive(1'b0, 2'b00, '0, '0);
        #12;
        chk("rst.a", 16'(a_out), 16'h00);
        chk("rst.cnt", 16'(count), 16'h0);
        chk("rst.pair", 16'(pair), 16'h0);
        reset_n = 1'b1;
        en = 1'b1;

        drive(1'b1, 2'b00, 8'hA5, 'x);
        step();
        chk("ld.q", 16'(q_out), 16'hA5);
        chk("ld.a", 16'(a_out), 16'h00);
        chk("ld.pair", 16'(pair), 16'h2);
        chk("ld.cnt", 16'(count), 16'h0);
        shifts(1);
        chk("sh.a", 16'(a_out), 16'h00);
        chk("sh.q", 16'(q_out), 16'h52);
        chk("sh.m1", 16'(q_m1), 16'h1);
        chk("sh.cnt", 16'(count), 16'h1);

        drive(1'b1, 2'b00, 8'h01, 'x);
        step();
        drive(1'b0, 2'b10, 'x, 8'h81);
        step();
        chk("sx.a", 16'(a_out), 16'hC0);
        chk("sx.q", 16'(q_out), 16'h80);
        chk("sx.m1", 16'(q_m1), 16'h1);

        drive(1'b1, 2'b00, 8'h3C, 'x);
        step();
        drive(1'b0, 2'b10, 'x, 8'h80);
        step();
        shifts(7);
        chk("lim.a", 16'(a_out), 16'hFF);
        chk("lim.q", 16'(q_out), 16'h80);
        chk("lim.m1", 16'(q_m1), 16'h0);
        chk("lim.cnt", 16'(count), 16'h8);
        chk("lim.done", 16'(done), 16'h1);
        shifts(1);
        chk("lim9.a", 16'(a_out), 16'hFF);
        chk("lim9.cnt", 16'(count), 16'h8);
        drive(1'b0, 2'b10, 'x, 8'h00);
        step();
        chk("lim10.a", 16'(a_out), 16'hFF);
        chk("lim10.q", 16'(q_out), 16'h80);
        drive(1'b0, 2'b11, 'x, 'x);
        step();
        chk("clrA.a", 16'(a_out), 16'h00);
        chk("clrA.q", 16'(q_out), 16'h80);
        chk("clrA.cnt", 16'(count), 16'h8);

        drive(1'b1, 2'b10, 8'h12, 8'h55);
        step();
        chk("pri.a", 16'(a_out), 16'h00);
        chk("pri.q", 16'(q_out), 16'h12);
        chk("pri.cnt", 16'(count), 16'h0);
        en = 1'b0;
        drive(1'b1, 2'b01, 8'h77, 'x);
        step();
        chk("en0.q", 16'(q_out), 16'h12);
        en = 1'b1;

        drive(1'b1, 2'b00, 8'hF0, 'x);
        step();
        shifts(3);
        chk("ar.cnt3", 16'(count), 16'h3);
        reset_n = 1'b0;
        #1;
        chk("ar.a", 16'(a_out), 16'h00);
        chk("ar.q", 16'(q_out), 16'h00);
        chk("ar.cnt", 16'(count), 16'h0);
        chk("ar.pair", 16'(pair), 16'h0);
        reset_n = 1'b1;
        shifts(1);
        chk("ar2.q", 16'(q_out), 16'h00);
        chk("ar2.a", 16'(a_out), 16'h00);
        chk("ar2.cnt", 16'(count), 16'h1);

`ifdef BOOTH_SHIFT_REG_SYNC_CLR_EN
        drive(1'b1, 2'b00, 8'hC3, 'x);
        step();
        shifts(5);
        chk("sc.cnt5", 16'(count), 16'h5);
        en = 1'b0; clr = 1'b1;
        drive(1'b0, 2'b01, 'x, 'x);
        step();
        chk("sc.a", 16'(a_out), 16'h00);
        chk("sc.q", 16'(q_out), 16'h00);
        chk("sc.cnt", 16'(count), 16'h0);
        clr = 1'b0; en = 1'b1;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
